// File: rtl/vlsu_req_arbiter.sv
// Shares the fragmenter request port between the load and store queues, one direction at a time.
// Latency: grant to frag_req_valid_o is 1 cycle; backpressure: a held output slot or MaxOutstanding in flight drops both readies.
module vlsu_req_arbiter #(
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned BurstMax       = 8,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ld_req_valid_i,
    output logic                ld_req_ready_o,
    input  logic [ReqWidth-1:0] ld_req_i,
    input  logic                st_req_valid_i,
    output logic                st_req_ready_o,
    input  logic [ReqWidth-1:0] st_req_i,
    output logic                frag_req_valid_o,
    input  logic                frag_req_ready_i,
    output logic [ReqWidth-1:0] frag_req_o,
    output logic                frag_req_is_load_o,
    input  logic                ld_done_i,
    input  logic                st_done_i,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                busy_o
);

    localparam int unsigned BurstWidth = $clog2(BurstMax + 1);

    typedef enum logic [1:0] {
        S_LD,
        S_DRAIN_ST,
        S_ST,
        S_DRAIN_LD
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [BurstWidth-1:0] burst_q, burst_d;

    logic slot_free;
    logic cnt_full;
    logic burst_hit;
    logic switch_ld;
    logic switch_st;
    logic ld_grant;
    logic st_grant;
    logic grant;
    logic dec;
    logic ld_dir;
    logic opp_vld;
    logic enter_issue;

    assign slot_free = !frag_req_valid_o || frag_req_ready_i;
    assign cnt_full  = (cnt_q == CntWidth'(MaxOutstanding));
    assign burst_hit = (burst_q == BurstWidth'(BurstMax));

    // Yield to the other side when our side is idle or has used up its burst.
    assign switch_ld = st_req_valid_i && (!ld_req_valid_i || burst_hit);
    assign switch_st = ld_req_valid_i && (!st_req_valid_i || burst_hit);

    assign ld_req_ready_o = !rst_i && (state_q == S_LD) && slot_free && !cnt_full && !switch_ld;
    assign st_req_ready_o = !rst_i && (state_q == S_ST) && slot_free && !cnt_full && !switch_st;

    assign ld_grant = ld_req_valid_i && ld_req_ready_o;
    assign st_grant = st_req_valid_i && st_req_ready_o;
    assign grant    = ld_grant || st_grant;
    assign dec      = (ld_done_i || st_done_i) && (cnt_q != '0);

    // Direction of whatever is currently in flight (drain states still hold the old direction).
    assign ld_dir  = (state_q == S_LD) || (state_q == S_DRAIN_ST);
    assign opp_vld = ld_dir ? st_req_valid_i : ld_req_valid_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LD:       if (switch_ld)     state_d = S_DRAIN_ST;
            S_DRAIN_ST: if (cnt_q == '0)   state_d = S_ST;
            S_ST:       if (switch_st)     state_d = S_DRAIN_LD;
            S_DRAIN_LD: if (cnt_q == '0)   state_d = S_LD;
            default:                       state_d = S_LD;
        endcase
    end

    assign enter_issue = (state_d != state_q) && ((state_d == S_LD) || (state_d == S_ST));

    always_comb begin
        cnt_d = cnt_q;
        if (grant && !dec) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!grant && dec) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (enter_issue || !opp_vld) begin
            burst_d = '0;
        end else if (grant && !burst_hit) begin
            burst_d = burst_q + BurstWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= S_LD;
            cnt_q              <= '0;
            burst_q            <= '0;
            frag_req_valid_o   <= 1'b0;
            frag_req_o         <= '0;
            frag_req_is_load_o <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            if (grant) begin
                frag_req_valid_o   <= 1'b1;
                frag_req_o         <= ld_grant ? ld_req_i : st_req_i;
                frag_req_is_load_o <= ld_grant;
            end else if (frag_req_ready_i) begin
                frag_req_valid_o   <= 1'b0;
            end
        end
    end

    assign outstanding_o = cnt_q;
    assign busy_o        = (cnt_q != '0);

    a_done_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (ld_done_i || st_done_i) |-> (cnt_q != '0));
    a_ld_done_dir: assert property (@(posedge clk_i) disable iff (rst_i)
        ld_done_i |-> ld_dir);
    a_st_done_dir: assert property (@(posedge clk_i) disable iff (rst_i)
        st_done_i |-> !ld_dir);

endmodule

// File: tb/tb_vlsu_req_arbiter.sv
// Directed and randomized bench for vlsu_req_arbiter against a queue-based reference model.
module tb_vlsu_req_arbiter;

    localparam int RW    = 128;
    localparam int MAXO  = 4;
    localparam int BURST = 8;
    localparam int CW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ld_req_valid_i = 1'b0;
    logic          ld_req_ready_o;
    logic [RW-1:0] ld_req_i = '0;
    logic          st_req_valid_i = 1'b0;
    logic          st_req_ready_o;
    logic [RW-1:0] st_req_i = '0;
    logic          frag_req_valid_o;
    logic          frag_req_ready_i = 1'b0;
    logic [RW-1:0] frag_req_o;
    logic          frag_req_is_load_o;
    logic          ld_done_i = 1'b0;
    logic          st_done_i = 1'b0;
    logic [CW-1:0] outstanding_o;
    logic          busy_o;

    vlsu_req_arbiter #(
        .ReqWidth(RW),
        .MaxOutstanding(MAXO),
        .BurstMax(BURST)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ld_req_valid_i(ld_req_valid_i),
        .ld_req_ready_o(ld_req_ready_o),
        .ld_req_i(ld_req_i),
        .st_req_valid_i(st_req_valid_i),
        .st_req_ready_o(st_req_ready_o),
        .st_req_i(st_req_i),
        .frag_req_valid_o(frag_req_valid_o),
        .frag_req_ready_i(frag_req_ready_i),
        .frag_req_o(frag_req_o),
        .frag_req_is_load_o(frag_req_is_load_o),
        .ld_done_i(ld_done_i),
        .st_done_i(st_done_i),
        .outstanding_o(outstanding_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: in-flight requests as a queue, plus the direction being served.
    logic [RW-1:0] inflight_q[$];
    bit            m_dir_ld = 1'b1;
    bit            m_drain  = 1'b0;
    int            m_streak = 0;
    bit            m_vld    = 1'b0;
    logic [RW-1:0] m_dat    = '0;
    bit            m_isld   = 1'b1;

    // Grant-run statistics observed on the DUT ports.
    bit stats_on  = 1'b0;
    bit last_ld   = 1'b1;
    int run_len   = 0;
    int max_run   = 0;
    int n_ld_gnt  = 0;
    int n_st_gnt  = 0;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic note_grant(input bit is_ld);
        if (is_ld) n_ld_gnt++; else n_st_gnt++;
        if (run_len != 0 && is_ld == last_ld) run_len++;
        else run_len = 1;
        last_ld = is_ld;
        if (run_len > max_run) max_run = run_len;
    endtask

    task automatic cycle(input bit ldv, input bit stv, input bit rdy, input bit want_done, input bit rst);
        bit ldd, std, exp_lr, exp_sr, same_v, other_v, want_sw, can_issue, grant, entering;
        int pre_size;
        logic [RW-1:0] ldp, stp;
        ldp = {$urandom, $urandom, $urandom, $urandom};
        stp = {$urandom, $urandom, $urandom, $urandom};
        ldd = 1'b0;
        std = 1'b0;
        // Only retire requests the fragmenter has already taken out of the slot.
        if (want_done && inflight_q.size() > (m_vld ? 1 : 0)) begin
            if (m_dir_ld) ldd = 1'b1; else std = 1'b1;
        end
        same_v  = m_dir_ld ? ldv : stv;
        other_v = m_dir_ld ? stv : ldv;
        want_sw = other_v && (!same_v || m_streak == BURST);
        can_issue = !rst && !m_drain && (!m_vld || rdy) && (inflight_q.size() < MAXO) && !want_sw;
        exp_lr = can_issue && m_dir_ld;
        exp_sr = can_issue && !m_dir_ld;
        grant  = can_issue && same_v;

        rst_i = rst;
        ld_req_valid_i = ldv;
        st_req_valid_i = stv;
        ld_req_i = ldp;
        st_req_i = stp;
        frag_req_ready_i = rdy;
        ld_done_i = ldd;
        st_done_i = std;
        #1;
        chk("ld_ready", RW'(ld_req_ready_o), RW'(exp_lr));
        chk("st_ready", RW'(st_req_ready_o), RW'(exp_sr));
        if (stats_on && ld_req_valid_i && ld_req_ready_o) note_grant(1'b1);
        if (stats_on && st_req_valid_i && st_req_ready_o) note_grant(1'b0);

        @(posedge clk_i);
        if (rst) begin
            inflight_q.delete();
            m_dir_ld = 1'b1;
            m_drain  = 1'b0;
            m_streak = 0;
            m_vld    = 1'b0;
            m_dat    = '0;
            m_isld   = 1'b1;
        end else begin
            pre_size = inflight_q.size();
            if (m_vld && rdy) m_vld = 1'b0;
            if (grant) begin
                m_vld  = 1'b1;
                m_dat  = m_dir_ld ? ldp : stp;
                m_isld = m_dir_ld;
                inflight_q.push_back(m_dat);
            end
            if ((ldd || std) && inflight_q.size() > 0) void'(inflight_q.pop_front());
            entering = m_drain && (pre_size == 0);
            if (entering || !other_v) m_streak = 0;
            else if (grant && m_streak < BURST) m_streak++;
            if (entering) begin
                m_drain  = 1'b0;
                m_dir_ld = !m_dir_ld;
            end else if (!m_drain && want_sw) begin
                m_drain = 1'b1;
            end
        end

        @(negedge clk_i);
        chk("frag_valid", RW'(frag_req_valid_o), RW'(m_vld));
        chk("frag_payload", frag_req_o, m_dat);
        chk("frag_is_load", RW'(frag_req_is_load_o), RW'(m_isld));
        chk("outstanding", RW'(outstanding_o), RW'(inflight_q.size()));
        chk("busy", RW'(busy_o), RW'(inflight_q.size() != 0));
    endtask

    initial begin
        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Three loads back to back, then three done pulses
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("three_loads_outstanding", RW'(outstanding_o), RW'(3));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("three_loads_retired", RW'(outstanding_o), RW'(0));

        // Outstanding cap: six loads offered, four granted, one done frees a slot
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("cap_reached", RW'(outstanding_o), RW'(MAXO));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Direction switch waits for loads to drain
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Both queues saturated: bursts alternate, neither side starves
        stats_on = 1'b1;
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        stats_on = 1'b0;
        chk("burst_max_run", RW'(max_run), RW'(BURST));
        chk("burst_ld_served", RW'(n_ld_gnt >= 16), RW'(1));
        chk("burst_st_served", RW'(n_st_gnt >= 16), RW'(1));
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Output backpressure for five cycles, then release
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of traffic, pending load granted right after
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("midreset_outstanding", RW'(outstanding_o), RW'(0));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_reset_grant", RW'(frag_req_valid_o), RW'(1));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
                  $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
